// File: rtl/job_dispatcher_pkg.sv
// Shared types and default sizing for the job dispatcher and its job FIFO.
package job_dispatcher_pkg;

    localparam int unsigned DW_DEF    = 8;
    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned TMO_DEF   = 64;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        RESULT    = 2'd3
    } state_e;

endpackage

// File: rtl/job_dispatcher_job_fifo.sv
// Job queue: DEPTH-entry circular buffer; an extra pointer bit separates full from empty.
module job_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/job_dispatcher.sv
// Queues host jobs, starts the datapath controller one job at a time, and returns
// each result to the host, abandoning a job whose done strobe never arrives.
module job_dispatcher
    import job_dispatcher_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned TMO   = TMO_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            job_valid,
    output logic            job_ready,
    input  logic [DW-1:0]   job_data,
    output logic            s,
    input  logic            input_en,
    output logic [DW-1:0]   x_out,
    input  logic            done,
    input  logic [2*DW-1:0] result_in,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [2*DW-1:0] res_data,
    output logic            timeout_err,
    output logic            busy,
    output logic [7:0]      job_count
);

    localparam int unsigned CW = (TMO > 1) ? $clog2(TMO) : 1;
    localparam int unsigned RW = 2 * DW;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   x_out_q, x_out_d;
    logic            s_q, s_d;
    logic            res_valid_q, res_valid_d;
    logic [RW-1:0]   res_data_q, res_data_d;
    logic            timeout_err_q, timeout_err_d;
    logic            busy_q, busy_d;
    logic [7:0]      job_count_q, job_count_d;

    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [DW-1:0]   fifo_head;

    // The operand is held in x_out for the whole job, so the load strobe needs no action.
    logic            unused_input_en;
    assign unused_input_en = input_en;

    assign fifo_push = job_valid && !fifo_full;
    assign job_ready = !fifo_full;

    job_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_job_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (job_data),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state and registered-output logic; the head stays queued until its job ends.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        x_out_d       = x_out_q;
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        job_count_d   = job_count_q;
        timeout_err_d = 1'b0;
        fifo_pop      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty && !res_valid_q) begin
                    state_d = START;
                    x_out_d = fifo_head;
                end
            end
            START: begin
                state_d = WAIT_DONE;
                cnt_d   = '0;
            end
            WAIT_DONE: begin
                if (done) begin
                    state_d     = RESULT;
                    res_data_d  = result_in;
                    res_valid_d = 1'b1;
                    job_count_d = job_count_q + 8'd1;
                    fifo_pop    = 1'b1;
                    cnt_d       = '0;
                end else if (cnt_q == CW'(TMO - 1)) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                    fifo_pop      = 1'b1;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        s_d    = (state_d == START);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            x_out_q       <= '0;
            s_q           <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            job_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            x_out_q       <= x_out_d;
            s_q           <= s_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
            job_count_q   <= job_count_d;
        end
    end

    assign s           = s_q;
    assign x_out       = x_out_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;
    assign job_count   = job_count_q;

endmodule
